kws_frame_window: RTL
=====================

// Module: kws_frame_window
// PURPOSE
//  Audio framing/windowing stage directly upstream of the 32-point FFT. Buffers a mono sample stream,
//  cuts overlapping frames (FRAME_SIZE long, every HOP_SIZE samples), applies a Hann window and
//  bursts each frame into the FFT via its valid_in/ready interface. Imag output is always zero.
// PARAMETERS
//  DATA_WIDTH  16  sample/output width, signed two's complement
//  FRAME_SIZE  32  samples per frame; must equal FFT size
//  HOP_SIZE    16  new samples between frames; 1..FRAME_SIZE
//  COEF_WIDTH  16  window coefficient width, unsigned Q1.14
// PORTS
//  clock            in   1           rising-edge clock
//  reset            in   1           asynchronous, active-high
//  sample_valid_in  in   1           sample_in valid this cycle; no backpressure
//  sample_in        in   DATA_WIDTH  signed audio sample
//  fft_ready_in     in   1           FFT ready (idle, accepts frame start)
//  frame_valid_out  out  1           windowed sample valid (to FFT valid_in)
//  frame_real_out   out  DATA_WIDTH  windowed sample
//  frame_imag_out   out  DATA_WIDTH  constant 0
//  frame_start_out  out  1           high with sample 0 of each frame
//  overflow_out     out  1           sticky: a pending frame was dropped
// BEHAVIOUR
//  - Clock/reset: one clock; reset is asynchronous and active-high. Reset clears all state/pointers;
//    all outputs 0. Reset mid-frame aborts the burst; re-priming needs FRAME_SIZE new samples.
//  - Buffer: circular RAM, depth 2*FRAME_SIZE, wr_ptr wraps modulo depth; one write per valid sample.
//  - Trigger: first at the FRAME_SIZE-th sample after reset, then at every HOP_SIZE-th sample.
//    Frame = most recent FRAME_SIZE samples incl. the triggering one; start snapshot = wr_addr+1-FRAME_SIZE.
//  - FSM: PRIME (count to FRAME_SIZE) -> WAIT_READY -> EMIT -> WAIT_READY if pending, else COLLECT;
//    COLLECT -> WAIT_READY on next trigger.
//  - Start: in WAIT_READY with fft_ready_in=1 at edge N -> EMIT from N+1 (read idx 0);
//    frame_valid_out=1 with sample 0 at N+2, samples 1..31 on N+3..N+33, contiguous.
//    fft_ready_in ignored once a burst starts (FFT drops ready after first sample).
//  - Window: w[n]=round(16384*0.5*(1-cos(2*pi*n/(FRAME_SIZE-1)))), symmetric (half ROM mirrored);
//    w[0]=w[31]=0x0000, w[15]=w[16]=0x3FD6.
//  - Arithmetic: out = (sample*w[n]) >>> 14 from 32-bit signed product, truncate; w<1.0 so no saturation.
//  - Pending: at most one. Trigger during EMIT -> pending, served after burst. Trigger while a frame
//    is pending or waiting in WAIT_READY -> older frame discarded, newest snapshot kept, overflow_out=1.
//  - Samples arriving during EMIT/WAIT_READY are stored normally; depth 2*FRAME_SIZE with
//    HOP_SIZE<=FRAME_SIZE guarantees an emitting or pending frame is never overwritten.
//  - Sample write and trigger in same cycle as burst end: burst completes, new frame becomes pending.
//  - frame_start_out/frame_valid_out deassert the cycle after sample 31.
// CONFIGURATION
//  KWS_PREEMPH_EN defined: pre-emphasis on write, y=x-x_prev+(x_prev>>>5) (coef 31/32),
//    saturated to DATA_WIDTH; x_prev resets to 0, updates per valid sample. Windowing uses y.
//  KWS_PREEMPH_EN undefined: raw samples stored; no extra logic.
// TESTING
//  1 32 samples of 0x4000, fft_ready_in=1 -> 32 outputs = w[n]: out0=0x0000, out15=out16=0x3FD6,
//    out31=0x0000, imag all 0, frame_start_out only with out0, latency per BEHAVIOUR.
//  2 Ramp x[n]=n, 48 samples -> frame1 uses 0..31; frame2 after sample 47 uses 16..47:
//    out[k]=((16+k)*w[k])>>>14.
//  3 fft_ready_in=0 through 64 samples -> overflow_out=1; on ready, one frame of samples 32..63
//    only.
//  4 One sample every cycle during EMIT -> current burst unchanged; next frame matches bit-exact model.
//  5 reset pulse at burst sample 10 -> outputs 0 on reset; no frame until 32 new samples;
//    overflow_out cleared.
//  6 KWS_PREEMPH_EN, constant 0x4000 -> stored y0=0x4000, y1..=0x0200; full-scale step saturates
//    at 0x7FFF/0x8000.

Source files
------------

// File: rtl/kws_frame_window.sv
// kws_frame_window: buffers a mono sample stream, cuts overlapping Hann-windowed frames and bursts them to the FFT.
// Define KWS_PREEMPH_EN to apply first-order pre-emphasis (coef 31/32) to samples before they are stored.
module kws_frame_window #(
    parameter int DATA_WIDTH = 16,
    parameter int FRAME_SIZE = 32,
    parameter int HOP_SIZE   = 16,
    parameter int COEF_WIDTH = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  sample_valid_in,
    input  logic [DATA_WIDTH-1:0] sample_in,
    input  logic                  fft_ready_in,
    output logic                  frame_valid_out,
    output logic [DATA_WIDTH-1:0] frame_real_out,
    output logic [DATA_WIDTH-1:0] frame_imag_out,
    output logic                  frame_start_out,
    output logic                  overflow_out
);
    localparam int AW   = $clog2(2 * FRAME_SIZE);
    localparam int IW   = $clog2(FRAME_SIZE);
    localparam int CW   = $clog2(FRAME_SIZE + 1);
    localparam int PW   = DATA_WIDTH + COEF_WIDTH + 1;
    localparam int FRAC = COEF_WIDTH - 2;
    // First half of the symmetric Hann window, Q1.14; the second half is read mirrored.
    localparam logic [COEF_WIDTH-1:0] WIN [FRAME_SIZE/2] = '{
        16'd0,     16'd168,   16'd664,   16'd1468,  16'd2548,  16'd3859,  16'd5347,  16'd6952,
        16'd8607,  16'd10245, 16'd11800, 16'd13206, 16'd14408, 16'd15355, 16'd16008, 16'd16342
    };

    typedef enum logic [1:0] {PRIME, COLLECT, WAIT_READY, EMIT} state_t;

    state_t                state;
    logic [DATA_WIDTH-1:0] ram [2*FRAME_SIZE];
    logic [DATA_WIDTH-1:0] wr_data;
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         cur_start;
    logic [AW-1:0]         pend_start;
    logic [AW-1:0]         snap;
    logic [AW-1:0]         rd_addr;
    logic [CW-1:0]         cnt;
    logic [IW-1:0]         idx;
    logic [IW-2:0]         half_idx;
    logic [COEF_WIDTH-1:0] coef;
    logic signed [PW-1:0]  prod;
    logic                  pend;
    logic                  trig;

    assign trig           = sample_valid_in && (cnt == ((state == PRIME) ? CW'(FRAME_SIZE - 1) : CW'(HOP_SIZE - 1)));
    assign snap           = wr_ptr - AW'(FRAME_SIZE - 1);
    assign rd_addr        = cur_start + AW'(idx);
    assign half_idx       = idx[IW-1] ? ~idx[IW-2:0] : idx[IW-2:0];
    assign coef           = WIN[half_idx];
    assign prod           = PW'($signed(ram[rd_addr])) * PW'($signed({1'b0, coef}));
    assign frame_imag_out = '0;

`ifdef KWS_PREEMPH_EN
    logic [DATA_WIDTH-1:0]  x_prev;
    logic signed [DATA_WIDTH+1:0] xs;
    logic signed [DATA_WIDTH+1:0] pv;
    logic signed [DATA_WIDTH+1:0] pre_sum;

    assign xs      = (DATA_WIDTH + 2)'($signed(sample_in));
    assign pv      = (DATA_WIDTH + 2)'($signed(x_prev));
    assign pre_sum = xs - pv + (pv >>> 5);
    // Saturate whenever the top three bits disagree (result outside DATA_WIDTH range).
    assign wr_data = (pre_sum[DATA_WIDTH+1:DATA_WIDTH-1] == 3'b000 || pre_sum[DATA_WIDTH+1:DATA_WIDTH-1] == 3'b111)
                   ? pre_sum[DATA_WIDTH-1:0]
                   : {pre_sum[DATA_WIDTH+1], {(DATA_WIDTH-1){~pre_sum[DATA_WIDTH+1]}}};

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            x_prev <= '0;
        else if (sample_valid_in)
            x_prev <= sample_in;
    end
`else
    assign wr_data = sample_in;
`endif

    always_ff @(posedge clock) begin
        if (sample_valid_in)
            ram[wr_ptr] <= wr_data;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state           <= PRIME;
            wr_ptr          <= '0;
            cnt             <= '0;
            idx             <= '0;
            cur_start       <= '0;
            pend_start      <= '0;
            pend            <= 1'b0;
            frame_valid_out <= 1'b0;
            frame_start_out <= 1'b0;
            frame_real_out  <= '0;
            overflow_out    <= 1'b0;
        end else begin
            frame_valid_out <= 1'b0;
            frame_start_out <= 1'b0;
            frame_real_out  <= '0;
            if (sample_valid_in) begin
                wr_ptr <= wr_ptr + AW'(1);
                cnt    <= trig ? '0 : cnt + CW'(1);
            end
            case (state)
                PRIME, COLLECT: begin
                    if (trig) begin
                        state     <= WAIT_READY;
                        cur_start <= snap;
                    end
                end
                WAIT_READY: begin
                    if (fft_ready_in) begin
                        state <= EMIT;
                        idx   <= '0;
                        if (trig) begin
                            pend       <= 1'b1;
                            pend_start <= snap;
                        end
                    end else if (trig) begin
                        cur_start    <= snap;
                        overflow_out <= 1'b1;
                    end
                end
                default: begin
                    frame_valid_out <= 1'b1;
                    frame_start_out <= idx == '0;
                    frame_real_out  <= DATA_WIDTH'(prod >>> FRAC);
                    idx             <= idx + IW'(1);
                    if (trig) begin
                        pend         <= 1'b1;
                        pend_start   <= snap;
                        overflow_out <= overflow_out | pend;
                    end
                    // Last sample of the burst: hand over to the newest queued frame, if any.
                    if (idx == IW'(FRAME_SIZE - 1)) begin
                        state     <= (trig || pend) ? WAIT_READY : COLLECT;
                        cur_start <= trig ? snap : pend_start;
                        pend      <= 1'b0;
                    end
                end
            endcase
        end
    end
endmodule
